measurement_sequencer: RTL and testbench

//  Dual-slope conversion sequencer for the voltmeter. Drives trigger/stop of the 0..999 pulse counter,

---
 rtl/measurement_sequencer_pkg.sv | 20 ++
 rtl/measurement_sequencer_wrap_elapsed_calc.sv | 35 +++
 rtl/measurement_sequencer.sv | 165 ++++++++++++++++
 tb/tb_measurement_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/measurement_sequencer_pkg.sv
// Shared types and constants for the dual-slope measurement sequencer.
// Pulse-counter geometry and FSM state encoding live here.
package measurement_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_UP,
    ST_RUN_DOWN,
    ST_CALC,
    ST_DONE
  } state_e;

  localparam int WRAP_MOD  = 1000;
  localparam int MAX_COUNT = 999;
  localparam int INC_COUNT = 998;

  localparam int CNT_W  = 10;
  localparam int WRAP_W = 8;

endpackage

// File: rtl/measurement_sequencer_wrap_elapsed_calc.sv
// Elapsed run-down clocks from wrap count and base/end counter values.
// The increment tick precedes the 999->0 wrap, so end==999 drops one wrap.
module wrap_elapsed_calc
  import measurement_sequencer_pkg::*;
#(
  parameter int RESULT_W = 20
) (
  input  logic [WRAP_W-1:0]   wraps_i,
  input  logic [CNT_W-1:0]    base_i,
  input  logic [CNT_W-1:0]    end_i,
  input  logic                overrange_i,
  output logic [RESULT_W-1:0] result_o
);

  logic [RESULT_W-1:0] wraps_adj;
  logic [RESULT_W-1:0] scaled;

  // wraps*1000 as 1024-16-8, then add the partial-wrap span
  always_comb begin
    wraps_adj = RESULT_W'(wraps_i);
    if (end_i == CNT_W'(MAX_COUNT)) begin
      wraps_adj = wraps_adj - RESULT_W'(1);
    end
    scaled = (wraps_adj << 10)
           - (wraps_adj << 4)
           - (wraps_adj << 3);
    result_o = scaled
             + RESULT_W'(end_i)
             - RESULT_W'(base_i);
    if (overrange_i) begin
      result_o = '1;
    end
  end

endmodule

// File: rtl/measurement_sequencer.sv
// Dual-slope conversion sequencer: run-up, run-down, result handshake.
// Drives pulse-counter trigger/stop and the integrator switches.
module measurement_sequencer
  import measurement_sequencer_pkg::*;
#(
  parameter int RUNUP_WRAPS   = 10,
  parameter int TIMEOUT_WRAPS = 40,
  parameter int RESULT_W      = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                comp_i,
  input  logic                increment_i,
  input  logic [CNT_W-1:0]    pulse_count_i,
  output logic                trigger_o,
  output logic                stop_o,
  output logic                integrate_o,
  output logic                deintegrate_o,
  output logic                busy_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [RESULT_W-1:0] result_o,
  output logic                overrange_o
);

  localparam logic [WRAP_W-1:0] RUNUP_N =
    WRAP_W'(RUNUP_WRAPS);
  localparam logic [WRAP_W-1:0] TMO_N =
    WRAP_W'(TIMEOUT_WRAPS);

  state_e              state_q;
  logic [WRAP_W-1:0]   wraps_q;
  logic [WRAP_W-1:0]   wraps_d;
  logic [CNT_W-1:0]    base_q;
  logic [CNT_W-1:0]    end_q;
  logic                first_q;
  logic                timeout_q;
  logic                trigger_q;
  logic                stop_q;
  logic                integ_q;
  logic                deint_q;
  logic                busy_q;
  logic                valid_q;
  logic                ovr_q;
  logic [RESULT_W-1:0] result_q;
  logic [RESULT_W-1:0] calc_res;

  assign wraps_d = wraps_q + WRAP_W'(increment_i);

  wrap_elapsed_calc #(
    .RESULT_W (RESULT_W)
  ) u_calc (
    .wraps_i     (wraps_q),
    .base_i      (base_q),
    .end_i       (end_q),
    .overrange_i (timeout_q),
    .result_o    (calc_res)
  );

  // Conversion FSM with registered switch/handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wraps_q   <= '0;
      base_q    <= '0;
      end_q     <= '0;
      first_q   <= 1'b0;
      timeout_q <= 1'b0;
      trigger_q <= 1'b0;
      stop_q    <= 1'b0;
      integ_q   <= 1'b0;
      deint_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      trigger_q <= 1'b0;
      stop_q    <= 1'b0;
      first_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            trigger_q <= 1'b1;
            wraps_q   <= '0;
            timeout_q <= 1'b0;
            integ_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN_UP;
          end
        end
        ST_RUN_UP: begin
          if (abort_i) begin
            stop_q  <= 1'b1;
            integ_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (wraps_q == RUNUP_N) begin
            wraps_q <= '0;
            integ_q <= 1'b0;
            deint_q <= 1'b1;
            first_q <= 1'b1;
            state_q <= ST_RUN_DOWN;
          end else begin
            wraps_q <= wraps_d;
          end
        end
        ST_RUN_DOWN: begin
          if (first_q) begin
            base_q <= pulse_count_i;
          end
          if (abort_i) begin
            stop_q  <= 1'b1;
            deint_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!comp_i) begin
            end_q   <= pulse_count_i;
            stop_q  <= 1'b1;
            deint_q <= 1'b0;
            state_q <= ST_CALC;
          end else if (increment_i && wraps_d == TMO_N) begin
            timeout_q <= 1'b1;
            stop_q    <= 1'b1;
            deint_q   <= 1'b0;
            state_q   <= ST_CALC;
          end else begin
            wraps_q <= wraps_d;
          end
        end
        ST_CALC: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            result_q <= calc_res;
            ovr_q    <= timeout_q;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (abort_i || result_ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trigger_o      = trigger_q;
  assign stop_o         = stop_q;
  assign integrate_o    = integ_q;
  assign deintegrate_o  = deint_q;
  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign result_o       = result_q;
  assign overrange_o    = ovr_q;

endmodule

// File: tb/tb_measurement_sequencer.sv
// Randomised and directed bench for measurement_sequencer.
// Includes a stand-in 0..999 pulse counter and an elapsed-clock model.
module tb_measurement_sequencer;

  localparam int RUNUP = 2;
  localparam int TMO   = 3;
  localparam int RW    = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          comp = 1'b1;
  logic          ready = 1'b0;
  logic          inc;
  logic [9:0]    pc = '0;
  logic          pc_en = 1'b0;
  logic          trigger_o, stop_o;
  logic          integrate_o, deintegrate_o;
  logic          busy_o, result_valid_o;
  logic [RW-1:0] result_o;
  logic          overrange_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  measurement_sequencer #(
    .RUNUP_WRAPS   (RUNUP),
    .TIMEOUT_WRAPS (TMO),
    .RESULT_W      (RW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .abort_i        (abort),
    .comp_i         (comp),
    .increment_i    (inc),
    .pulse_count_i  (pc),
    .trigger_o      (trigger_o),
    .stop_o         (stop_o),
    .integrate_o    (integrate_o),
    .deintegrate_o  (deintegrate_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (ready),
    .result_o       (result_o),
    .overrange_o    (overrange_o)
  );

  // pulse counter: trigger clears and enables, stop freezes
  always @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      pc_en <= 1'b0;
    end else if (stop_o) begin
      pc_en <= 1'b0;
    end else if (trigger_o) begin
      pc_en <= 1'b1;
      pc <= '0;
    end else if (pc_en) begin
      pc <= (pc == 10'd999) ? 10'd0 : pc + 10'd1;
    end
  end
  assign inc = pc_en && (pc == 10'd998);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference: run-down result is simply elapsed clocks
  typedef enum {P_IDLE, P_UP, P_DOWN, P_CALC, P_DONE} ph_t;
  ph_t           ph = P_IDLE;
  int            ticks = 0;
  int            el = 0;
  logic          e_trig = 1'b0;
  logic          e_stop = 1'b0;
  logic [RW-1:0] e_res = '0;
  logic          e_ovr = 1'b0;

  always @(posedge clk) begin
    e_trig = 1'b0;
    e_stop = 1'b0;
    if (rst) begin
      ph = P_IDLE;
      e_res = '0;
      e_ovr = 1'b0;
    end else begin
      case (ph)
        P_IDLE:
          if (start && !abort) begin
            ph = P_UP;
            e_trig = 1'b1;
            ticks = 0;
          end
        P_UP:
          if (abort) begin
            ph = P_IDLE;
            e_stop = 1'b1;
          end else if (ticks == RUNUP) begin
            ph = P_DOWN;
            ticks = 0;
            el = 0;
          end else begin
            ticks += int'(inc);
          end
        P_DOWN:
          if (abort) begin
            ph = P_IDLE;
            e_stop = 1'b1;
          end else if (!comp) begin
            e_res = RW'(el);
            e_ovr = 1'b0;
            e_stop = 1'b1;
            ph = P_CALC;
          end else if (inc && ticks + 1 == TMO) begin
            e_res = '1;
            e_ovr = 1'b1;
            e_stop = 1'b1;
            ph = P_CALC;
          end else begin
            ticks += int'(inc);
            el++;
          end
        P_CALC: ph = abort ? P_IDLE : P_DONE;
        P_DONE: if (abort || ready) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  // cycle-by-cycle compare plus event bookkeeping
  int   cyc_n = 0;
  int   n_trig = 0;
  int   n_stop = 0;
  int   rd_start = 0;
  int   stop_at = 0;
  logic deint_prev = 1'b0;

  always @(negedge clk) begin
    cyc_n++;
    chk("trigger", trigger_o, e_trig);
    chk("stop", stop_o, e_stop);
    chk("integrate", integrate_o, ph == P_UP);
    chk("deintegrate", deintegrate_o, ph == P_DOWN);
    chk("busy", busy_o, ph != P_IDLE);
    chk("valid", result_valid_o, ph == P_DONE);
    if (ph == P_DONE) begin
      chk("result", result_o, e_res);
      chk("overrange", overrange_o, e_ovr);
    end
    if (trigger_o) n_trig++;
    if (stop_o) begin
      n_stop++;
      stop_at = cyc_n;
    end
    if (deintegrate_o && !deint_prev) rd_start = cyc_n;
    deint_prev = deintegrate_o;
  end

  function automatic logic sel(input int w);
    case (w)
      0: return deintegrate_o;
      1: return result_valid_o;
      default: return stop_o;
    endcase
  endfunction

  task automatic noise_start(input bit noise);
    start = noise && busy_o && ($urandom % 6 == 0);
  endtask

  task automatic wait_on(input int w, input int limit,
                         input string nm, input bit noise,
                         output int n);
    n = 0;
    while (!sel(w) && n < limit) begin
      @(negedge clk);
      noise_start(noise);
      n++;
    end
    if (!sel(w)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: timed out after %0d cycles",
               nm, n);
    end
  endtask

  // one conversion; k<0 keeps comp high (timeout)
  task automatic conv(input int k, input int rdly,
                      input bit noise,
                      output logic [RW-1:0] res,
                      output logic ovr,
                      output int lat);
    int n;
    comp = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_on(0, 4000, "deint", noise, n);
    if (k >= 0) begin
      repeat (k) begin
        @(negedge clk);
        noise_start(noise);
      end
      comp = 1'b0;
    end
    wait_on(1, 4000, "valid", noise, n);
    lat = n;
    res = result_o;
    ovr = overrange_o;
    repeat (rdly) begin
      @(negedge clk);
      noise_start(noise);
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    comp = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] res;
    logic          ovr;
    int            lat;
    int            n;

    // reset with start held
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_trigger", trigger_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_ovr", overrange_o, 0);
    chk("rst_integ", integrate_o, 0);

    // nominal 1500 clocks
    n_trig = 0;
    n_stop = 0;
    conv(1500, 0, 1'b0, res, ovr, lat);
    chk("nom_result", res, 1500);
    chk("nom_ovr", ovr, 0);
    chk("nom_latency", lat, 2);
    chk("nom_trig_cnt", n_trig, 1);
    chk("nom_stop_cnt", n_stop, 1);
    chk("nom_stop_time", stop_at - rd_start, 1501);
    chk("model_nom", e_res, 1500);

    // end at count 999 and immediate fall
    conv(999, 0, 1'b0, res, ovr, lat);
    chk("b999_result", res, 999);
    chk("model_b999", e_res, 999);
    conv(0, 0, 1'b0, res, ovr, lat);
    chk("b0_result", res, 0);
    chk("b0_ovr", ovr, 0);

    // timeout
    conv(-1, 0, 1'b0, res, ovr, lat);
    chk("tmo_ovr", ovr, 1);
    chk("tmo_result", res, 20'hFFFFF);
    chk("tmo_stop_time", stop_at - rd_start, 2999);

    // held result, start ignored while busy
    n_trig = 0;
    conv(1500, 20, 1'b1, res, ovr, lat);
    chk("hs_result", res, 1500);
    chk("hs_trig_cnt", n_trig, 1);
    chk("hs_idle", busy_o, 0);

    // abort mid run-up
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_stop", stop_o, 1);
    chk("ab_busy", busy_o, 0);
    @(negedge clk);
    chk("ab_stop_off", stop_o, 0);
    chk("ab_valid", result_valid_o, 0);

    // abort beats start in idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abst_trig", trigger_o, 0);
    chk("abst_busy", busy_o, 0);

    // reset mid run-down
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_on(0, 4000, "deint_rst", 1'b0, n);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rrd_busy", busy_o, 0);
    chk("rrd_deint", deintegrate_o, 0);
    chk("rrd_stop", stop_o, 0);
    @(negedge clk);

    // randomised conversions and aborts
    for (int i = 0; i < 8; i++) begin
      if ($urandom % 5 == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(1, 2500)) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        int k;
        k = ($urandom % 4 == 0) ? -1
          : int'($urandom_range(0, 1500));
        conv(k, int'($urandom_range(0, 5)), 1'b1,
             res, ovr, lat);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
